// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential floating-point multiplier with valid/ready handshakes.
// Significands are multiplied one bit per cycle. The product is then
// normalised and rounded to nearest-even. Subnormal inputs and outputs are
// flushed to zero.
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     invalid,
    output logic                     inexact
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int P  = MAN_W + 1;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t            state_q;
    logic              sign_q;
    logic [EXP_W-1:0]  ea_q, eb_q;
    logic [P-1:0]      mcand_q, mpl_q;
    logic [2*P-1:0]    acc_q;
    logic [CW-1:0]     cnt_q;
    logic [W-1:0]      result_q;
    logic              out_valid_q, ovf_q, unf_q, inv_q, inx_q;

    // Operand classification, looked at only on the accept edge.
    logic [EXP_W-1:0] ea_in, eb_in;
    logic [MAN_W-1:0] ma_in, mb_in;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
    always_comb begin
        ea_in   = a[W-2:MAN_W];
        eb_in   = b[W-2:MAN_W];
        ma_in   = a[MAN_W-1:0];
        mb_in   = b[MAN_W-1:0];
        sign_in = a[W-1] ^ b[W-1];
        a_zero  = (ea_in == '0);
        b_zero  = (eb_in == '0);
        a_inf   = (&ea_in) && (ma_in == '0);
        b_inf   = (&eb_in) && (mb_in == '0);
        a_nan   = (&ea_in) && (ma_in != '0);
        b_nan   = (&eb_in) && (mb_in != '0);
    end

    // One shift-add step: add the multiplicand to the upper half if the
    // current multiplier bit is set, then shift the whole accumulator right.
    logic [P:0]     sum_d;
    logic [2*P-1:0] acc_d;
    always_comb begin
        sum_d = {1'b0, acc_q[2*P-1:P]} + (mpl_q[0] ? {1'b0, mcand_q} : {(P+1){1'b0}});
        acc_d = {sum_d, acc_q[P-1:1]};
    end

    // Normalise, round to nearest-even and form the biased exponent.
    logic              norm, g_bit, s_bit, rup, carry, ovf_d, unf_d;
    logic [2*P-2:0]    sh;
    logic [MAN_W-1:0]  kept;
    logic [MAN_W:0]    man_r;
    logic [EW-1:0]     exp_d;
    always_comb begin
        norm  = acc_q[2*P-1];
        sh    = norm ? acc_q[2*P-2:0] : {acc_q[2*P-3:0], 1'b0};
        kept  = sh[2*P-2:P];
        g_bit = sh[P-1];
        s_bit = |sh[P-2:0];
        rup   = g_bit & (s_bit | kept[0]);
        man_r = {1'b0, kept} + (MAN_W+1)'(rup);
        carry = man_r[MAN_W];
        exp_d = EW'(ea_q) + EW'(eb_q) - EW'(BIAS) + EW'(norm) + EW'(carry);
        ovf_d = !exp_d[EW-1] && (exp_d >= EMAX);
        unf_d = exp_d[EW-1] || (exp_d == '0);
    end

    // Control FSM with registered result and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
            inx_q       <= 1'b0;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            mcand_q     <= '0;
            mpl_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    sign_q  <= sign_in;
                    ea_q    <= ea_in;
                    eb_q    <= eb_in;
                    mcand_q <= {1'b1, ma_in};
                    mpl_q   <= {1'b1, mb_in};
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    unf_q   <= 1'b0;
                    inv_q   <= 1'b0;
                    inx_q   <= 1'b0;
                    if (a_nan || b_nan) begin
                        result_q    <= QNAN;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                        result_q    <= QNAN;
                        inv_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (a_inf || b_inf) begin
                        result_q    <= {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (a_zero || b_zero) begin
                        result_q    <= {sign_in, {(W-1){1'b0}}};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    mpl_q <= mpl_q >> 1;
                    if (cnt_q == CW'(P - 1)) state_q <= NORM;
                    else                     cnt_q   <= cnt_q + 1'b1;
                end
                NORM: begin
                    if (ovf_d) begin
                        result_q <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ovf_q    <= 1'b1;
                        inx_q    <= 1'b1;
                    end else if (unf_d) begin
                        result_q <= {sign_q, {(W-1){1'b0}}};
                        unf_q    <= 1'b1;
                        inx_q    <= 1'b1;
                    end else begin
                        result_q <= {sign_q, exp_d[EXP_W-1:0], man_r[MAN_W-1:0]};
                        inx_q    <= g_bit | s_bit;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;
    assign inexact   = inx_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq at default single-precision widths.
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        overflow, underflow, invalid, inexact;
    int          total = 0;
    int          bad   = 0;

    fp_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow),
        .invalid(invalid), .inexact(inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure latency in edges (accept edge counts as 1),
    // check result/flags, then complete the output handshake.
    task automatic run_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags,
                          input int exp_lat);
        int lat;
        a = oa; b = ob; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_flags"}, {28'd0, overflow, underflow, invalid, inexact}, {28'd0, exp_flags});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ovdrop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_irdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic        stable;
        int          w;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_irdy", {31'd0, in_ready}, 32'd0);
        chk("rst_flags", {28'd0, overflow, underflow, invalid, inexact}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_irdy", {31'd0, in_ready}, 32'd1);

        // flags order: {overflow, underflow, invalid, inexact}
        run_op("mul3x2p5", 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 26);
        run_op("tie_odd",  32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 26);
        run_op("one_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26);
        run_op("ovf",      32'h7F000000, 32'h40000000, 32'h7F800000, 4'b1001, 26);
        run_op("unf",      32'h00800000, 32'h3F000000, 32'h00000000, 4'b0101, 26);
        run_op("max_sq",   32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 26);
        run_op("neg_mul",  32'hC0400000, 32'h40200000, 32'hC0F00000, 4'b0000, 26);
        run_op("zinf",     32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b0010, 1);
        run_op("ninf",     32'hBF800000, 32'h7F800000, 32'hFF800000, 4'b0000, 1);
        run_op("nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);
        run_op("negzero",  32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1);
        run_op("subnorm",  32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, 1);

        // Backpressure: result held, in_ready low, extra in_valid ignored.
        a = 32'h40400000; b = 32'h40200000; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h3F800000; b = 32'h3F800000;
        w = 1;
        while (!out_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("bp_lat", w, 26);
        held = result;
        chk("bp_res", held, 32'h40F00000);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_ovdrop", {31'd0, out_valid}, 32'd0);
        chk("bp_irdy", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of MUL aborts the operation.
        a = 32'h40400000; b = 32'h40200000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mr_ov", {31'd0, out_valid}, 32'd0);
        chk("mr_res", result, 32'd0);
        chk("mr_irdy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mr_rel_irdy", {31'd0, in_ready}, 32'd1);
        run_op("post_rst", 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Parametrised, sequential IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output. It is the next-generation replacement for the combinational single-precision multiplier path in the FP ALU. It adds:
- configurable exponent and mantissa widths,
- a one-bit-per-cycle shift-add significand datapath,
- round-to-nearest-even,
- special-value handling,
- exception flags.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width (hidden bit excluded); P = MAN_W+1
- BIAS, 2^(EXP_W-1)-1, exponent bias
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a, b  in  EXP_W+MAN_W+1 each  operands {sign, exp, mantissa}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  EXP_W+MAN_W+1  product
- overflow, underflow, invalid, inexact  out  1 each  exception flags, valid with out_valid

## Operation
- States: IDLE, MUL, NORM, DONE. in_ready = (state==IDLE) and not in reset.
- **Accept** when in_valid && in_ready. a and b are captured and later input changes are ignored.
- **Classification at accept.** Exp==0 means zero: subnormal inputs are flushed to signed zero and raise no flag. Exp all-ones with mantissa==0 is inf; with mantissa!=0 it is NaN.
- **Special cases.** These go IDLE->DONE directly:
  - Any NaN operand -> canonical qNaN: sign 0, exp all-ones, mantissa MSB 1, rest 0. No flag.
  - 0*inf -> canonical qNaN, invalid=1.
  - inf*(finite or inf) -> ±inf.
  - 0*finite -> ±0.
- **Sign.** sign = sa^sb for every non-NaN result.
- **MUL.** Runs P cycles. Significands include the hidden 1. Each cycle examines one multiplier bit, LSB first, and shift-adds into a 2P-bit accumulator. A bit counter runs 0..P-1.
- **NORM** (1 cycle), with product bits indexed 2P-1 down to 0:
  - norm = product[2P-1].
  - Kept mantissa = MAN_W bits below the leading 1.
  - G = next bit; S = OR of all remaining bits.
  - Round up iff G & (S | LSB).
  - Rounding carry-out renormalises: mantissa becomes 0 and the exponent increments.
  - inexact = G|S.
- **Exponent.** E = ea + eb - BIAS + norm + carry, computed signed in EXP_W+2 bits.
  - E >= 2^EXP_W-1 -> ±inf, overflow=1, inexact=1.
  - E <= 0 -> ±0 (flush-to-zero), underflow=1, inexact=1.
- **DONE.** result and flags are held stable while out_valid=1 and until out_ready=1. On that edge the block moves to IDLE. in_ready rises the following cycle, so a new accept never happens in the same cycle as the output handshake.

## Timing
- **Reset** (rst_n low at a clock edge):
  - state=IDLE; out_valid, result and all flags = 0.
  - in_ready=0 while rst_n is low and 1 in the first cycle after release.
  - Reset mid-operation aborts it; the partial result is discarded and never presented.
- **Normal operand, accept at edge T:** MUL covers cycles T+1..T+P, NORM is T+P+1, and out_valid=1 from T+P+2. With the default widths, out_valid asserts 26 cycles after accept.
- **Special case, accept at edge T:** out_valid=1 at T+1.
- **Throughput:** one operation in flight. in_valid held during busy states is ignored and not queued.
- out_valid and result are registered outputs, with no combinational path from in_* to out_*.

## Test plan
- 0x40400000 (3.0) * 0x40200000 (2.5) -> result 0x40F00000 (7.5), all flags 0, out_valid exactly 26 cycles after accept.
- 0x3F800001 * 0x3FC00000 (rounding tie, odd LSB) -> 0x3FC00002, inexact=1. Also 0x3F800000*0x3F800000 -> 0x3F800000, inexact=0.
- 0x7F000000 * 0x40000000 -> 0x7F800000, overflow=1, inexact=1. Also 0x00800000 * 0x3F000000 -> 0x00000000, underflow=1, inexact=1.
- 0x00000000 * 0xFF800000 -> 0x7FC00000, invalid=1, out_valid 1 cycle after accept. Also 0xBF800000 * 0x7F800000 -> 0xFF800000, no flags.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. result stays stable and in_ready=0 throughout. Then raise out_ready: out_valid falls after that edge, and in_ready=1 one cycle later.
- Drop rst_n during cycle 10 of MUL. Next cycle: out_valid=0, result=0, in_ready=0. After release, in_ready=1 and a fresh 3.0*2.5 completes correctly.
